// File: rtl/secded_encoder.sv
// Two-stage pipelined (39,32) extended-Hamming SECDED encoder with valid/ready flow control.
// Defining SECDED_ERR_INJECT_EN adds inj_en/inj_pos for single-bit error injection at the output.
module secded_encoder #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 39,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef SECDED_ERR_INJECT_EN
  input  logic              inj_en,
  input  logic [5:0]        inj_pos,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [CNT_W-1:0]  enc_count
);

  localparam int HAM_W = CODE_W - 1;

  // Bit i is set when codeword position i+1 is covered by Hamming parity bit k.
  function automatic logic [HAM_W-1:0] cover_mask(input int k);
    logic [HAM_W-1:0] m;
    m = '0;
    for (int i = 0; i < HAM_W; i++) begin
      m[i] = (((i + 1) >> k) % 2) != 0;
    end
    return m;
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [CNT_W-1:0]  enc_count_q, enc_count_d;

  logic              s2_free;
  logic              accept;
  logic              xfer;
  logic              deliver;

  logic [HAM_W-1:0]  s1_scat;
  logic [5:0]        s1_par;
  logic [HAM_W-1:0]  s1_ham;
  logic [CODE_W-1:0] s2_code;

`ifdef SECDED_ERR_INJECT_EN
  logic              s1_inj_en_q, s1_inj_en_d;
  logic [5:0]        s1_inj_pos_q, s1_inj_pos_d;
`endif

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign xfer     = s1_valid_q && s2_free;
  assign deliver  = out_valid_q && out_ready;

  // Data bits occupy every non-power-of-two position, in ascending order.
  always_comb begin
    s1_scat        = '0;
    s1_scat[2]     = s1_data_q[0];
    s1_scat[6:4]   = s1_data_q[3:1];
    s1_scat[14:8]  = s1_data_q[10:4];
    s1_scat[30:16] = s1_data_q[25:11];
    s1_scat[37:32] = s1_data_q[31:26];
  end

  for (genvar k = 0; k < 6; k++) begin : g_par
    assign s1_par[k] = ^(s1_scat & cover_mask(k));
  end

  always_comb begin
    s1_ham     = s1_scat;
    s1_ham[0]  = s1_par[0];
    s1_ham[1]  = s1_par[1];
    s1_ham[3]  = s1_par[2];
    s1_ham[7]  = s1_par[3];
    s1_ham[15] = s1_par[4];
    s1_ham[31] = s1_par[5];
  end

  // Injection flips the final codeword, so the overall parity no longer matches.
  always_comb begin
    s2_code = {^s1_ham, s1_ham};
`ifdef SECDED_ERR_INJECT_EN
    if (s1_inj_en_q && (s1_inj_pos_q < 6'(CODE_W))) begin
      s2_code[s1_inj_pos_q] = ~s2_code[s1_inj_pos_q];
    end
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
    end else if (xfer) begin
      s1_valid_d = 1'b0;
    end
  end

`ifdef SECDED_ERR_INJECT_EN
  always_comb begin
    s1_inj_en_d  = s1_inj_en_q;
    s1_inj_pos_d = s1_inj_pos_q;
    if (accept) begin
      s1_inj_en_d  = inj_en;
      s1_inj_pos_d = inj_pos;
    end
  end
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_code_d  = s2_code;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign enc_count_d = enc_count_q + CNT_W'(deliver);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      enc_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      enc_count_q <= enc_count_d;
    end
  end

`ifdef SECDED_ERR_INJECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inj_en_q  <= 1'b0;
      s1_inj_pos_q <= '0;
    end else begin
      s1_inj_en_q  <= s1_inj_en_d;
      s1_inj_pos_q <= s1_inj_pos_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign enc_count = enc_count_q;

endmodule

// File: tb/tb_secded_encoder.sv
// Self-checking bench for secded_encoder: directed vectors, random stream, backpressure and reset.
module tb_secded_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [38:0] out_code;
  logic [15:0] enc_count;
`ifdef SECDED_ERR_INJECT_EN
  logic        inj_en = 1'b0;
  logic [5:0]  inj_pos = '0;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_out = 0;
  bit          acc;
  logic [38:0] exp_q[$];
  logic [31:0] dat_q[$];

  always #5 clk = ~clk;

  secded_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SECDED_ERR_INJECT_EN
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .enc_count (enc_count)
  );

  // Reference: data fills non-power-of-two positions; the Hamming bits equal
  // the XOR of the positions of all set data bits; bit 38 makes total parity even.
  function automatic logic [38:0] ref_code(input logic [31:0] d, input logic ie, input logic [5:0] ip);
    logic [38:0] c;
    int          j;
    int          syn;
    c = '0;
    j = 0;
    syn = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[j];
        if (d[j]) syn = syn ^ pos;
        j++;
      end
    end
    for (int k = 0; k < 6; k++) c[(1 << k) - 1] = syn[k];
    c[38] = ^c[37:0];
    if (ie && ip < 6'd39) c[ip] = ~c[ip];
    return c;
  endfunction

  // Reference decoder with single-error correction.
  function automatic logic [31:0] decode(input logic [38:0] cw);
    logic [38:0] c;
    logic [31:0] d;
    int          syn;
    int          j;
    c = cw;
    d = '0;
    syn = 0;
    j = 0;
    for (int pos = 1; pos <= 38; pos++) if (c[pos-1]) syn = syn ^ pos;
    if ((^c) && syn >= 1 && syn <= 38) c[syn-1] = ~c[syn-1];
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = c[pos-1];
        j++;
      end
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs driven; evaluates handshakes, then advances one edge.
  task automatic tick();
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      check("out_has_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        check("out_code_order", out_code, exp_q.pop_front());
        check("decode_roundtrip", decode(out_code), dat_q.pop_front());
      end
    end
    if (acc) begin
`ifdef SECDED_ERR_INJECT_EN
      exp_q.push_back(ref_code(in_data, inj_en, inj_pos));
`else
      exp_q.push_back(ref_code(in_data, 1'b0, 6'd0));
`endif
      dat_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [31:0] d, input logic [38:0] code_exp, input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    tick();
    check({tag, "_accepted"}, acc, 1'b1);
    in_valid = 1'b0;
    check({tag, "_not_yet_valid"}, out_valid, 1'b0);
    tick();
    check({tag, "_valid_at_2"}, out_valid, 1'b1);
    check({tag, "_code"}, out_code, code_exp);
    tick();
  endtask

  logic [31:0] w[3];
  int          idx;
  logic [31:0] rw;

  initial begin
    #3;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_enc_count", enc_count, 16'd0);
    check("rst_out_code", out_code, 39'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    single(32'h0000_0000, 39'h00_0000_0000, "zero");
    check("count_after_zero", enc_count, 16'd1);
    single(32'h0000_0001, 39'h40_0000_0007, "d0");
    single(32'h8000_0000, 39'h20_8000_000A, "d31");
    check("count_after_vectors", enc_count, 16'd3);

    rst_n = 1'b0;
    #1;
    check("clr_enc_count", enc_count, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    n_out = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
      check("stream_accept", acc, 1'b1);
    end
    check("stream_one_per_cycle", n_out, 98);
    in_valid = 1'b0;
    tick();
    tick();
    check("stream_outputs", n_out, 100);
    check("stream_queue_empty", exp_q.size(), 0);
    check("stream_enc_count", enc_count, 16'd100);

    n_out = 0;
    idx = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    in_valid = 1'b1;
    in_data  = w[0];
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (acc) idx++;
      if (idx < 3) in_data = w[idx];
      if (cyc >= 2) begin
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_out_stable", out_code, exp_q[0]);
      end
    end
    check("bp_accepted_two", idx, 2);
    out_ready = 1'b1;
    #1;
    check("bp_release_same_cycle", in_ready, 1'b1);
    for (int cyc = 0; cyc < 10 && !(idx == 3 && exp_q.size() == 0); cyc++) begin
      tick();
      if (acc) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    check("bp_all_accepted", idx, 3);
    check("bp_drained", n_out, 3);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_enc_count", enc_count, 16'd103);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    tick();
    in_data = $urandom;
    tick();
    in_valid = 1'b0;
    check("full_out_valid", out_valid, 1'b1);
    check("full_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_enc_count", enc_count, 16'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    dat_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_reset_no_output", out_valid, 1'b0);
    rw = $urandom;
    single(rw, ref_code(rw, 1'b0, 6'd0), "post_reset");
    check("post_reset_count", enc_count, 16'd1);

`ifdef SECDED_ERR_INJECT_EN
    inj_en  = 1'b1;
    inj_pos = 6'd2;
    single(32'h0000_0001, 39'h40_0000_0003, "inj_pos2");
    inj_pos = 6'd45;
    single(32'h0000_0001, 39'h40_0000_0007, "inj_pos45");
    inj_en = 1'b0;
    check("inj_count", enc_count, 16'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
